id_ex_stage: RTL and testbench

- ID/EX pipeline register directly upstream of the ALU. It latches decoded operands, immediate, ALU function and destination info from decode.
- It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB results, then drives the ALU A, B and FUNC inputs.
- It supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

---
 rtl/id_ex_stage_pkg.sv | 33 +++
 rtl/id_ex_stage_fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 182 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: datapath width, register-address
// width, ALU function codes and the forward-select encoding.
// The datapath width comes from the `WORD_SIZE macro (default 16).
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package id_ex_stage_pkg;

    localparam int WORD_SIZE = `WORD_SIZE;
    localparam int REG_AW    = 2;

    // ALU function codes; the ALU itself performs the LHI <<8
    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_AND = 4'b0010;
    localparam logic [3:0] FUNC_OR  = 4'b0011;
    localparam logic [3:0] FUNC_XOR = 4'b0100;
    localparam logic [3:0] FUNC_SLL = 4'b0101;
    localparam logic [3:0] FUNC_SRL = 4'b0110;
    localparam logic [3:0] FUNC_SRA = 4'b0111;
    localparam logic [3:0] FUNC_SLT = 4'b1000;
    localparam logic [3:0] FUNC_MOV = 4'b1001;
    localparam logic [3:0] FUNC_LHI = 4'b1010;

    // Which source an operand was taken from
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MW  = 2'd1,
        FWD_EXM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux: picks the youngest matching producer
// (EX/MEM over MEM/WB) or falls back to the stored register value.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REG_AW-1:0]    rs,
    input  logic [WORD_SIZE-1:0] reg_val,
    input  logic                 exm_valid,
    input  logic                 exm_reg_write,
    input  logic [REG_AW-1:0]    exm_rd,
    input  logic [WORD_SIZE-1:0] exm_result,
    input  logic                 mw_valid,
    input  logic                 mw_reg_write,
    input  logic [REG_AW-1:0]    mw_rd,
    input  logic [WORD_SIZE-1:0] mw_result,
    output logic [WORD_SIZE-1:0] operand,
    output fwd_sel_e             sel
);

    // Select the newest in-flight value for rs; EX/MEM is younger than MEM/WB
    always_comb begin
        sel     = FWD_REG;
        operand = reg_val;
        if (exm_valid && exm_reg_write && (exm_rd == rs)) begin
            sel     = FWD_EXM;
            operand = exm_result;
        end else if (mw_valid && mw_reg_write && (mw_rd == rs)) begin
            sel     = FWD_MW;
            operand = mw_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with RAW forwarding from the
// EX/MEM and MEM/WB slots. Forwarding is built only when ID_EX_FWD_EN is
// defined; otherwise operands come straight from the stored register values.
//
// Control semantics, evaluated at each rising clk edge:
//   flush         -> slot becomes a bubble (all fields 0), wins over stall
//   stall         -> slot holds; stored operand values refresh with the
//                    currently forwarded values so a retiring producer is kept
//   neither       -> slot loads from decode
// reset is asynchronous and overrides both.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [REG_AW-1:0]    id_rs1,
    input  logic [REG_AW-1:0]    id_rs2,
    input  logic [WORD_SIZE-1:0] id_rs1_val,
    input  logic [WORD_SIZE-1:0] id_rs2_val,
    input  logic [WORD_SIZE-1:0] id_imm,
    input  logic                 id_use_imm,
    input  logic [3:0]           id_func,
    input  logic [REG_AW-1:0]    id_rd,
    input  logic                 id_reg_write,
    input  logic                 exm_valid,
    input  logic                 exm_reg_write,
    input  logic [REG_AW-1:0]    exm_rd,
    input  logic [WORD_SIZE-1:0] exm_result,
    input  logic                 mw_valid,
    input  logic                 mw_reg_write,
    input  logic [REG_AW-1:0]    mw_rd,
    input  logic [WORD_SIZE-1:0] mw_result,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_func,
    output logic                 ex_valid,
    output logic [REG_AW-1:0]    ex_rd,
    output logic                 ex_reg_write
);

    logic                 valid_q, valid_d;
    logic                 reg_write_q, reg_write_d;
    logic [REG_AW-1:0]    rd_q, rd_d;
    logic [3:0]           func_q, func_d;
    logic [WORD_SIZE-1:0] imm_q, imm_d;
    logic                 use_imm_q, use_imm_d;
    logic [REG_AW-1:0]    rs1_q, rs1_d;
    logic [REG_AW-1:0]    rs2_q, rs2_d;
    logic [WORD_SIZE-1:0] rs1_val_q, rs1_val_d;
    logic [WORD_SIZE-1:0] rs2_val_q, rs2_val_d;

    logic [WORD_SIZE-1:0] op_a;
    logic [WORD_SIZE-1:0] op_b;

`ifdef ID_EX_FWD_EN
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    fwd_mux u_fwd_a (
        .rs            (rs1_q),
        .reg_val       (rs1_val_q),
        .exm_valid     (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mw_valid      (mw_valid),
        .mw_reg_write  (mw_reg_write),
        .mw_rd         (mw_rd),
        .mw_result     (mw_result),
        .operand       (op_a),
        .sel           (sel_a)
    );

    fwd_mux u_fwd_b (
        .rs            (rs2_q),
        .reg_val       (rs2_val_q),
        .exm_valid     (exm_valid),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mw_valid      (mw_valid),
        .mw_reg_write  (mw_reg_write),
        .mw_rd         (mw_rd),
        .mw_result     (mw_result),
        .operand       (op_b),
        .sel           (sel_b)
    );

    // Select codes are a debug hook only
    logic unused_fwd_sel;
    assign unused_fwd_sel = ^{sel_a, sel_b};
`else
    // No forwarding: software spaces dependent instructions with NOPs
    assign op_a = rs1_val_q;
    assign op_b = rs2_val_q;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exm_valid, exm_reg_write, exm_rd, exm_result,
                                 mw_valid, mw_reg_write, mw_rd, mw_result,
                                 rs1_q, rs2_q};
`endif

    // Next slot contents: flush beats stall beats load
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        func_d      = func_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = '0;
            func_d      = 4'b0000;
            imm_d       = '0;
            use_imm_d   = 1'b0;
            rs1_d       = '0;
            rs2_d       = '0;
            rs1_val_d   = '0;
            rs2_val_d   = '0;
        end else if (stall) begin
`ifdef ID_EX_FWD_EN
            rs1_val_d = op_a;
            rs2_val_d = op_b;
`endif
        end else begin
            valid_d     = id_valid;
            reg_write_d = id_reg_write & id_valid;
            rd_d        = id_rd;
            func_d      = id_func;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rs1_val_d   = id_rs1_val;
            rs2_val_d   = id_rs2_val;
        end
    end

    // Slot register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            func_q      <= 4'b0000;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            func_q      <= func_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
        end
    end

    assign alu_a        = op_a;
    assign alu_b        = use_imm_q ? imm_q : op_b;
    assign alu_func     = func_q;
    assign ex_valid     = valid_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// stall/flush/forwarding traffic against a behavioural slot model.
// Works with or without ID_EX_FWD_EN defined.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int W  = WORD_SIZE;
    localparam int AW = REG_AW;
`ifdef ID_EX_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          stall, flush;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2;
    logic [W-1:0]  id_rs1_val, id_rs2_val, id_imm;
    logic          id_use_imm;
    logic [3:0]    id_func;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          exm_valid, exm_reg_write;
    logic [AW-1:0] exm_rd;
    logic [W-1:0]  exm_result;
    logic          mw_valid, mw_reg_write;
    logic [AW-1:0] mw_rd;
    logic [W-1:0]  mw_result;
    logic [W-1:0]  alu_a, alu_b;
    logic [3:0]    alu_func;
    logic          ex_valid;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_func(id_func), .id_rd(id_rd),
        .id_reg_write(id_reg_write),
        .exm_valid(exm_valid), .exm_reg_write(exm_reg_write),
        .exm_rd(exm_rd), .exm_result(exm_result),
        .mw_valid(mw_valid), .mw_reg_write(mw_reg_write),
        .mw_rd(mw_rd), .mw_result(mw_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: contents of the EX slot as an abstract record
    logic          m_valid, m_rw, m_use_imm;
    logic [AW-1:0] m_rd, m_rs1, m_rs2;
    logic [3:0]    m_func;
    logic [W-1:0]  m_imm, m_v1, m_v2;

    // Value an instruction reading register rs would see right now
    function automatic logic [W-1:0] fwd_val(input logic [AW-1:0] rs, input logic [W-1:0] v);
        logic hit_e, hit_m;
        hit_e = exm_valid && exm_reg_write && (exm_rd == rs);
        hit_m = mw_valid && mw_reg_write && (mw_rd == rs);
        if (FWD_ON && hit_e) return exm_result;
        if (FWD_ON && hit_m) return mw_result;
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_use_imm = 0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
        m_func = '0; m_imm = '0; m_v1 = '0; m_v2 = '0;
    endtask

    task automatic model_edge();
        logic [W-1:0] n1, n2;
        if (reset || flush) begin
            model_reset();
        end else if (stall) begin
            n1 = fwd_val(m_rs1, m_v1);
            n2 = fwd_val(m_rs2, m_v2);
            m_v1 = n1;
            m_v2 = n2;
        end else begin
            m_valid = id_valid; m_rw = id_reg_write && id_valid; m_rd = id_rd;
            m_func = id_func; m_imm = id_imm; m_use_imm = id_use_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_v1 = id_rs1_val; m_v2 = id_rs2_val;
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_q.push_back(fwd_val(m_rs1, m_v1));
        exp_q.push_back(m_use_imm ? m_imm : fwd_val(m_rs2, m_v2));
        exp_q.push_back(W'(m_func));
        exp_q.push_back(W'(m_valid));
        exp_q.push_back(W'(m_rd));
        exp_q.push_back(W'(m_rw && m_valid));
        check_eq({tag, "_alu_a"},    alu_a,               exp_q.pop_front());
        check_eq({tag, "_alu_b"},    alu_b,               exp_q.pop_front());
        check_eq({tag, "_alu_func"}, W'(alu_func),        exp_q.pop_front());
        check_eq({tag, "_ex_valid"}, W'(ex_valid),        exp_q.pop_front());
        check_eq({tag, "_ex_rd"},    W'(ex_rd),           exp_q.pop_front());
        check_eq({tag, "_ex_rw"},    W'(ex_reg_write),    exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [W-1:0] v1, input logic [W-1:0] v2, input logic [W-1:0] imm,
                            input logic ui, input logic [3:0] fn, input logic [AW-1:0] rd,
                            input logic rw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_val = v1; id_rs2_val = v2;
        id_imm = imm; id_use_imm = ui; id_func = fn; id_rd = rd; id_reg_write = rw;
    endtask

    task automatic drive_exm(input logic v, input logic wr, input logic [AW-1:0] rd, input logic [W-1:0] res);
        exm_valid = v; exm_reg_write = wr; exm_rd = rd; exm_result = res;
    endtask

    task automatic drive_mw(input logic v, input logic wr, input logic [AW-1:0] rd, input logic [W-1:0] res);
        mw_valid = v; mw_reg_write = wr; mw_rd = rd; mw_result = res;
    endtask

    // One clock edge, model update, then output check just after the edge
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive_random();
        drive_id(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                 W'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 10)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        drive_exm(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), W'($urandom));
        drive_mw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), W'($urandom));
        stall = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 9) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_id(1'b1, 2'd0, 2'd0, 16'h0005, 16'h0000, 16'h0000, 1'b0, FUNC_ADD, 2'd1, 1'b1);
        drive_exm(1'b0, 1'b0, 2'd0, '0);
        drive_mw(1'b0, 1'b0, 2'd0, '0);
        model_reset();

        // Reset value visible before any clock edge
        #2;
        check_eq("rst_ex_valid", W'(ex_valid), '0);
        check_eq("rst_alu_func", W'(alu_func), '0);
        check_eq("rst_alu_a", alu_a, '0);
        check_eq("rst_alu_b", alu_b, '0);
        check_eq("rst_ex_rw", W'(ex_reg_write), '0);
        @(negedge clk);
        reset = 1'b0;
        step("first_load");
        check_eq("first_load_a_lit", alu_a, 16'h0005);

        // EX/MEM wins over MEM/WB; falls back to MEM/WB
        drive_id(1'b1, 2'd1, 2'd0, 16'h0007, 16'h0000, 16'h0000, 1'b0, FUNC_ADD, 2'd3, 1'b1);
        step("fwd_load");
        drive_exm(1'b1, 1'b1, 2'd1, 16'h1234);
        drive_mw(1'b1, 1'b1, 2'd1, 16'hBEEF);
        #1;
        check_outputs("fwd_exm");
        check_eq("fwd_exm_lit", alu_a, FWD_ON ? 16'h1234 : 16'h0007);
        exm_valid = 1'b0;
        #1;
        check_outputs("fwd_mw");
        check_eq("fwd_mw_lit", alu_a, FWD_ON ? 16'hBEEF : 16'h0007);
        drive_mw(1'b0, 1'b0, 2'd0, '0);

        // Immediate B operand ignores a matching producer (LHI)
        drive_id(1'b1, 2'd0, 2'd2, 16'h0000, 16'h0099, 16'h00AB, 1'b1, FUNC_LHI, 2'd2, 1'b1);
        drive_exm(1'b1, 1'b1, 2'd2, 16'h5555);
        step("imm");
        check_eq("imm_b_lit", alu_b, 16'h00AB);
        check_eq("imm_func_lit", W'(alu_func), W'(FUNC_LHI));
        drive_exm(1'b0, 1'b0, 2'd0, '0);

        // Producer retiring from MEM/WB during a 2-cycle stall is captured
        drive_id(1'b1, 2'd0, 2'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, FUNC_SUB, 2'd1, 1'b1);
        step("stall_load");
        stall = 1'b1;
        drive_id(1'b1, 2'd3, 2'd3, 16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b1, FUNC_OR, 2'd3, 1'b0);
        drive_mw(1'b1, 1'b1, 2'd2, 16'h0042);
        step("stall_c1");
        drive_mw(1'b0, 1'b0, 2'd0, '0);
        #1;
        check_outputs("stall_c1_mwoff");
        step("stall_c2");
        check_eq("stall_b_lit", alu_b, FWD_ON ? 16'h0042 : 16'h0000);
        check_eq("stall_func_lit", W'(alu_func), W'(FUNC_SUB));
        stall = 1'b0;

        // Flush wins over stall at the same edge
        drive_id(1'b1, 2'd1, 2'd1, 16'h0011, 16'h0022, 16'h0000, 1'b0, FUNC_XOR, 2'd2, 1'b1);
        step("pre_flush");
        stall = 1'b1; flush = 1'b1;
        step("flush_stall");
        check_eq("flush_valid_lit", W'(ex_valid), '0);
        check_eq("flush_rw_lit", W'(ex_reg_write), '0);
        check_eq("flush_func_lit", W'(alu_func), '0);
        flush = 1'b0;

        // Reset in the middle of a stall, then a normal load
        drive_id(1'b1, 2'd2, 2'd1, 16'h0101, 16'h0202, 16'h0000, 1'b0, FUNC_AND, 2'd1, 1'b1);
        stall = 1'b0;
        step("pre_rst2");
        stall = 1'b1;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("mid_stall_rst");
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        step("post_rst2");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_random();
            #1;
            check_outputs("rnd_pre");
            step("rnd_post");
            if ($urandom_range(0, 49) == 0) begin
                #1;
                reset = 1'b1;
                model_reset();
                #1;
                check_outputs("rnd_rst");
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
